// File: rtl/cipher_mem_sequencer.sv
// cipher_mem_sequencer
//   Top-level controller between three byte-wide single-port RAMs (key,
//   plaintext, ciphertext) and a 64-bit block-cipher core. On an accepted
//   start it reads the 128-bit key once. For each block it then reads 8
//   plaintext bytes, launches the core, waits for the result under a watchdog
//   and writes the 8 result bytes back to the ciphertext RAM.
//
//   Ports
//     clk, rst_n           system clock, asynchronous active-low reset
//     start_i              job request, sampled only in IDLE
//     num_blocks_i         block count, latched on start and clamped to 2^(ADDR_W-3)
//     busy_o / done_o      job in progress / one-cycle end-of-job pulse
//     error_o              watchdog abort flag, held until the next accepted start
//     key_addr_o/key_dout_i  key RAM read port (1-cycle read latency)
//     pt_addr_o/pt_dout_i    plaintext RAM read port (1-cycle read latency)
//     ct_addr_o/ct_we_o/ct_din_o  ciphertext RAM write port
//     core_key_o/core_block_o/core_start_o  cipher core launch interface
//     core_done_i/core_result_i             cipher core result interface
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   IDLE      | waiting for start_i
//   LOAD_KEY  | 17 cycles: key_addr 0..15, key bytes captured one cycle later
//   LOAD_PT   | 9 cycles: pt_addr 8i..8i+7, plaintext captured one cycle later
//   START     | core_start pulse, watchdog armed
//   WAIT_CORE | waiting for core_done; watchdog expiry aborts the job
//   WRITE_CT  | 8 cycles writing result bytes to ct_addr 8i..8i+7
//   FINISH    | done pulse, back to IDLE
module cipher_mem_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-3:0] num_blocks_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-1:0] key_addr_o,
    input  logic [7:0]        key_dout_i,
    output logic [ADDR_W-1:0] pt_addr_o,
    input  logic [7:0]        pt_dout_i,
    output logic [ADDR_W-1:0] ct_addr_o,
    output logic              ct_we_o,
    output logic [7:0]        ct_din_o,
    output logic [127:0]      core_key_o,
    output logic [63:0]       core_block_o,
    output logic              core_start_o,
    input  logic              core_done_i,
    input  logic [63:0]       core_result_i
);

    localparam int NB_W = ADDR_W - 2;
    localparam logic [NB_W-1:0] NB_MAX = NB_W'(2 ** (ADDR_W - 3));
    localparam int WD_W = $clog2(TIMEOUT);
    // Watchdog counts down from TIMEOUT-1 so that exactly TIMEOUT cycles are
    // spent in WAIT_CORE before the abort.
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_PT,
        START,
        WAIT_CORE,
        WRITE_CT,
        FINISH
    } state_t;

    state_t            state_q;
    logic [4:0]        cnt_q;
    logic [WD_W-1:0]   wd_q;
    logic [NB_W-1:0]   nblk_q;
    logic [NB_W-1:0]   blk_q;
    logic [63:0]       res_q;

    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [ADDR_W-1:0] key_addr_q;
    logic [ADDR_W-1:0] pt_addr_q;
    logic [ADDR_W-1:0] ct_addr_q;
    logic              ct_we_q;
    logic [7:0]        ct_din_q;
    logic [127:0]      key_q;
    logic [63:0]       block_q;
    logic              core_start_q;

    logic [NB_W-1:0]   nblk_d;
    logic [NB_W-1:0]   blk_nxt;
    logic              blk_last;
    logic [ADDR_W-1:0] blk_base;
    logic [ADDR_W-1:0] nxt_base;

    always_comb begin
        nblk_d = num_blocks_i;
        if (num_blocks_i > NB_MAX) begin
            nblk_d = NB_MAX;
        end
    end

    assign blk_nxt  = blk_q + 1'b1;
    assign blk_last = (blk_nxt >= nblk_q);
    assign blk_base = {blk_q[ADDR_W-4:0], 3'b000};
    assign nxt_base = {blk_nxt[ADDR_W-4:0], 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wd_q         <= '0;
            nblk_q       <= '0;
            blk_q        <= '0;
            res_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            key_addr_q   <= '0;
            pt_addr_q    <= '0;
            ct_addr_q    <= '0;
            ct_we_q      <= 1'b0;
            ct_din_q     <= '0;
            key_q        <= '0;
            block_q      <= '0;
            core_start_q <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        error_q <= 1'b0;
                        nblk_q  <= nblk_d;
                        blk_q   <= '0;
                        if (nblk_d == '0) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            busy_q     <= 1'b1;
                            cnt_q      <= 5'd16;
                            key_addr_q <= '0;
                            state_q    <= LOAD_KEY;
                        end
                    end
                end
                // cnt_q runs 16..0; the first cycle has no data yet and the
                // address stops advancing once byte 15 has been requested.
                LOAD_KEY: begin
                    if (cnt_q != 5'd16) begin
                        key_q <= {key_q[119:0], key_dout_i};
                    end
                    if (cnt_q > 5'd1) begin
                        key_addr_q <= key_addr_q + 1'b1;
                    end
                    if (cnt_q == '0) begin
                        cnt_q     <= 5'd8;
                        pt_addr_q <= '0;
                        state_q   <= LOAD_PT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                LOAD_PT: begin
                    if (cnt_q != 5'd8) begin
                        block_q <= {block_q[55:0], pt_dout_i};
                    end
                    if (cnt_q > 5'd1) begin
                        pt_addr_q <= pt_addr_q + 1'b1;
                    end
                    if (cnt_q == '0) begin
                        core_start_q <= 1'b1;
                        wd_q         <= WD_LOAD;
                        state_q      <= START;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                START: begin
                    state_q <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (core_done_i) begin
                        ct_we_q   <= 1'b1;
                        ct_addr_q <= blk_base;
                        ct_din_q  <= core_result_i[63:56];
                        res_q     <= {core_result_i[55:0], 8'h00};
                        cnt_q     <= 5'd7;
                        state_q   <= WRITE_CT;
                    end else if (wd_q == '0) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        wd_q <= wd_q - 1'b1;
                    end
                end
                WRITE_CT: begin
                    if (cnt_q == '0) begin
                        ct_we_q <= 1'b0;
                        if (blk_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            blk_q     <= blk_nxt;
                            pt_addr_q <= nxt_base;
                            cnt_q     <= 5'd8;
                            state_q   <= LOAD_PT;
                        end
                    end else begin
                        cnt_q     <= cnt_q - 1'b1;
                        ct_addr_q <= ct_addr_q + 1'b1;
                        ct_din_q  <= res_q[63:56];
                        res_q     <= {res_q[55:0], 8'h00};
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign key_addr_o   = key_addr_q;
    assign pt_addr_o    = pt_addr_q;
    assign ct_addr_o    = ct_addr_q;
    assign ct_we_o      = ct_we_q;
    assign ct_din_o     = ct_din_q;
    assign core_key_o   = key_q;
    assign core_block_o = block_q;
    assign core_start_o = core_start_q;

endmodule

// File: doc/cipher_mem_sequencer.md
Name: cipher_mem_sequencer

Overview:
- Sequences one 64-bit block-cipher core against three byte-wide single-port RAMs: key, plaintext and ciphertext.
- On start, it performs these steps:
  - reads the 128-bit key once;
  - for each of N blocks, reads 8 plaintext bytes, launches the core and waits for its result;
  - writes the 8 result bytes to the ciphertext RAM.
- It is the top-level controller between the memory banks and the cipher datapath.

Parameters:
- ADDR_W, 8: RAM address width. Each RAM holds 2^ADDR_W bytes.
- TIMEOUT, 1024: maximum number of cycles spent in WAIT_CORE before the job aborts. Must be ≥ 2.

Ports:
- clk  in  1  System clock; all logic on the rising edge.
- rst_n  in  1  Asynchronous active-low reset.
- start  in  1  Job request. Sampled only in IDLE.
- num_blocks  in  ADDR_W-2  Number of 8-byte blocks. Latched on start.
- busy  out  1  High from the cycle after start is accepted through the last write cycle.
- done  out  1  One-cycle pulse when the job ends (normal or abort).
- error  out  1  Timeout flag. Valid with done; held until the next accepted start.
- key_addr  out  ADDR_W  Key RAM address.
- key_dout  in  8  Key RAM read data. Registered, 1-cycle latency.
- pt_addr  out  ADDR_W  Plaintext RAM address.
- pt_dout  in  8  Plaintext RAM read data. 1-cycle latency.
- ct_addr  out  ADDR_W  Ciphertext RAM address.
- ct_we  out  1  Ciphertext RAM write enable.
- ct_din  out  8  Ciphertext RAM write data.
- core_key  out  128  Key to the core. Stable from LOAD_KEY end until IDLE.
- core_block  out  64  Plaintext block to the core. Stable during START and WAIT.
- core_start  out  1  One-cycle launch pulse.
- core_done  in  1  Core result-valid pulse.
- core_result  in  64  Core output. Captured when core_done is high in WAIT_CORE.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0. Reset is asynchronous at any time, including mid-job; ct_we drops immediately. No partial-job resume after reset.
- Byte order is big-endian: byte at base+0 is bits [MSB:MSB-7]. Key = {k[0]..k[15]}; block = {p[8i]..p[8i+7]}.
- RAM reads:
  - Address driven in cycle c gives data on *_dout in cycle c+1.
  - The sequencer captures on the edge ending cycle c+1.
  - Key and plaintext RAM write enables are not driven by this block.
- IDLE: busy=0.
  - start=1 latches num_blocks (values > 2^(ADDR_W-3) clamp to 2^(ADDR_W-3)), clears error and goes to LOAD_KEY.
  - num_blocks=0: go straight to FINISH, so done pulses 1 cycle after start with no memory access.
- LOAD_KEY: 17 cycles. key_addr = 0..15 in cycles 0..15; bytes captured in cycles 1..16. Then block index i=0 and go to LOAD_PT.
- LOAD_PT: 9 cycles. pt_addr = 8i+j, j=0..7; capture is offset by one cycle. Then START.
- START: 1 cycle. core_start=1, watchdog cleared, go to WAIT_CORE.
- WAIT_CORE:
  - core_done=1: capture core_result and go to WRITE_CT.
  - Watchdog reaches TIMEOUT with no core_done: set error and go to FINISH; remaining blocks are not processed.
  - core_done outside WAIT_CORE is ignored.
- WRITE_CT: 8 cycles. ct_we=1, ct_addr=8i+j, ct_din = result byte j.
  - If i+1 < N: i++ and go to LOAD_PT (key is not reloaded).
  - Otherwise go to FINISH.
- FINISH: 1 cycle. done=1, busy=0, then IDLE.
- Handshake rules:
  - start while not in IDLE is ignored (no queuing).
  - start held high in IDLE after FINISH launches a new job.
- Address arithmetic is ADDR_W bits. It cannot overflow because of the clamp: maximum address 8·32−1 = 255 for ADDR_W=8.
- Job latency, N blocks, core latency L (core_done L cycles after core_start):
  - busy duration = 17 + N·(9 + 1 + L + 8) cycles;
  - done in the next cycle.

Test Plan:
- Single block:
  - Stimulus: key RAM 00..0F, plaintext RAM 11 22 33 44 55 66 77 88, stub core with L=4 returning block XOR key[63:0]; start with num_blocks=1.
  - Required: core_key=0x000102030405060708090A0B0C0D0E0F, core_block=0x1122334455667788.
  - Required: ct[0..7] = 19 2B 39 4F 59 6B 79 87; busy high for 39 cycles; done pulses once; error=0.
- Multi-block:
  - Stimulus: num_blocks=3, plaintext bytes 0..23 = 0x00..0x17.
  - Required: exactly one key load (16 key reads total); core_start pulses 3 times; ct[0..23] correct; ct_we never high outside 0..23.
- Zero and clamp:
  - num_blocks=0 → done exactly 1 cycle after start, no RAM activity.
  - num_blocks=40 → 32 blocks processed; last write at ct_addr=255.
- Timeout:
  - Stimulus: TIMEOUT=16, core never asserts done, num_blocks=2.
  - Required: done with error=1 after 16 WAIT cycles; no ct_we; block 1 never loaded.
  - Required: the next start clears error.
- Reset and stray inputs:
  - rst_n low during WRITE_CT byte 3 → ct_we=0 asynchronously, all outputs 0, state IDLE.
  - Required: the following job runs normally.
  - start pulses mid-job and core_done pulses during LOAD_PT are both ignored.
